ordenador_burbuja: RTL and testbench

ORDENADOR_BURBUJA -- requirements
Module: ordenador_burbuja

---
 rtl/ordenador_pkg.sv | 14 +
 rtl/comparador_nbits.sv | 19 +
 rtl/ordenador_burbuja.sv | 126 ++++++++++++
 tb/tb_ordenador_burbuja.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ordenador_pkg.sv
// rtl/ordenador_pkg.sv - FSM state encoding and comparator result bit positions for ordenador_burbuja
package ordenador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int CMP_GT = 2;
    localparam int CMP_EQ = 1;
    localparam int CMP_LT = 0;

endpackage

// File: rtl/comparador_nbits.sv
// rtl/comparador_nbits.sv - unsigned WIDTH-bit comparator with one-hot greater/equal/less result
module comparador_nbits
    import ordenador_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [2:0]       result
);

    always_comb begin
        result         = '0;
        result[CMP_GT] = (a > b);
        result[CMP_EQ] = (a == b);
        result[CMP_LT] = (a < b);
    end

endmodule

// File: rtl/ordenador_burbuja.sv
// rtl/ordenador_burbuja.sv - sequential bubble sorter, one compare per cycle via a shared comparator
// Optional early exit on a swap-free pass: define ORDENADOR_EARLY_EXIT_EN.
module ordenador_burbuja
    import ordenador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    localparam int SWAP_W = $clog2(N * (N - 1) / 2 + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WIDTH-1:0]   data_in,
    output logic                 busy,
    output logic                 done,
    output logic [N*WIDTH-1:0]   data_out,
    output logic [SWAP_W-1:0]    swap_count
);

    localparam int IDX_W  = $clog2(N);
    localparam int PASS_W = $clog2(N);

    state_t            state;
    logic [WIDTH-1:0]  arr [N];
    logic [IDX_W-1:0]  idx;
    logic [PASS_W-1:0] pass;
    logic [SWAP_W-1:0] swap_cnt;
`ifdef ORDENADOR_EARLY_EXIT_EN
    logic              pass_swapped;
`endif

    logic [IDX_W-1:0]  idx_p1;
    logic [WIDTH-1:0]  elem_a;
    logic [WIDTH-1:0]  elem_b;
    logic [2:0]        cmp;
    logic              do_swap;
    logic              last_idx;
    logic              last_pass;
    logic              exit_now;

    assign idx_p1 = idx + IDX_W'(1);
    assign elem_a = arr[idx];
    assign elem_b = arr[idx_p1];

    comparador_nbits #(.WIDTH(WIDTH)) u_cmp (
        .a      (elem_a),
        .b      (elem_b),
        .result (cmp)
    );

    // Swap only on a clean "greater": ties stay put, which keeps the sort stable.
    assign do_swap   = cmp[CMP_GT] & ~(cmp[CMP_EQ] | cmp[CMP_LT]);
    assign last_idx  = (idx == IDX_W'(N - 2));
    assign last_pass = (pass == PASS_W'(N - 2));

    always_comb begin
`ifdef ORDENADOR_EARLY_EXIT_EN
        exit_now = last_pass || !(pass_swapped || do_swap);
`else
        exit_now = last_pass;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            data_out   <= '0;
            swap_count <= '0;
            idx        <= '0;
            pass       <= '0;
            swap_cnt   <= '0;
`ifdef ORDENADOR_EARLY_EXIT_EN
            pass_swapped <= 1'b0;
`endif
            for (int k = 0; k < N; k++) arr[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) arr[k] <= data_in[k*WIDTH +: WIDTH];
                        idx      <= '0;
                        pass     <= '0;
                        swap_cnt <= '0;
`ifdef ORDENADOR_EARLY_EXIT_EN
                        pass_swapped <= 1'b0;
`endif
                        busy     <= 1'b1;
                        state    <= SORT;
                    end
                end
                SORT: begin
                    if (do_swap) begin
                        arr[idx]    <= elem_b;
                        arr[idx_p1] <= elem_a;
                        swap_cnt    <= swap_cnt + SWAP_W'(1);
                    end
                    if (last_idx) begin
                        idx  <= '0;
                        pass <= pass + PASS_W'(1);
`ifdef ORDENADOR_EARLY_EXIT_EN
                        pass_swapped <= 1'b0;
`endif
                        if (exit_now) state <= FIN;
                    end else begin
                        idx <= idx_p1;
`ifdef ORDENADOR_EARLY_EXIT_EN
                        if (do_swap) pass_swapped <= 1'b1;
`endif
                    end
                end
                FIN: begin
                    for (int k = 0; k < N; k++) data_out[k*WIDTH +: WIDTH] <= arr[k];
                    swap_count <= swap_cnt;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ordenador_burbuja.sv
// tb/tb_ordenador_burbuja.sv - scoreboard bench for ordenador_burbuja (WIDTH=4, N=4)
module tb_ordenador_burbuja;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] data_out;
    logic [2:0]  swap_count;

    typedef struct {
        logic [15:0] data;
        logic [2:0]  swaps;
        int          start_cyc;
        int          lat;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_done = 1'b0;

`ifdef ORDENADOR_EARLY_EXIT_EN
    localparam int LAT_A    = 7;
    localparam int LAT_FLAT = 4;
`else
    localparam int LAT_A    = 10;
    localparam int LAT_FLAT = 10;
`endif

    ordenador_burbuja #(.WIDTH(4), .N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .busy       (busy),
        .done       (done),
        .data_out   (data_out),
        .swap_count (swap_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] pk(input logic [3:0] a0, input logic [3:0] a1,
                                       input logic [3:0] a2, input logic [3:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_done) check("done_one_cycle", int'(done), 0);
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("data_out", int'(data_out), int'(e.data));
                    check("swap_count", int'(swap_count), int'(e.swaps));
                    check("latency", cyc - e.start_cyc, e.lat);
                    check("busy_at_done", int'(busy), 0);
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic launch(input logic [15:0] din, input logic [15:0] dexp,
                          input logic [2:0] sw, input int lat, input bit track);
        exp_t e;
        @(negedge clk);
        data_in = din;
        start   = 1'b1;
        if (track) begin
            e.data = dexp; e.swaps = sw; e.start_cyc = cyc + 1; e.lat = lat;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) check("drain_timeout", n, 0);
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_data_out"}, int'(data_out), 0);
        check({tag, "_swap_count"}, int'(swap_count), 0);
    endtask

    initial begin
        exp_t e;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        launch(pk(15, 0, 5, 10), pk(0, 5, 10, 15), 3'd3, LAT_A, 1'b1);
        wait_drain();
        launch(pk(15, 10, 5, 0), pk(0, 5, 10, 15), 3'd6, 10, 1'b1);
        wait_drain();
        launch(pk(2, 15, 2, 0), pk(0, 2, 2, 15), 3'd4, 10, 1'b1);
        wait_drain();
        launch(pk(5, 5, 5, 5), pk(5, 5, 5, 5), 3'd0, LAT_FLAT, 1'b1);
        wait_drain();

        // Start during the job must not disturb it.
        launch(pk(15, 0, 5, 10), pk(0, 5, 10, 15), 3'd3, LAT_A, 1'b1);
        repeat (1) @(negedge clk);
        check("busy_mid_job", int'(busy), 1);
        data_in = pk(1, 1, 1, 1);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wait_drain();

        // Start held high: two back-to-back jobs, second accepted 11 edges after the first.
        @(negedge clk);
        data_in = pk(15, 10, 5, 0);
        start   = 1'b1;
        e.data = pk(0, 5, 10, 15); e.swaps = 3'd6; e.start_cyc = cyc + 1; e.lat = 10;
        q.push_back(e);
        e.start_cyc = cyc + 12;
        q.push_back(e);
        repeat (12) @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Reset in the middle of SORT.
        launch(pk(15, 0, 5, 10), '0, 3'd0, 0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_zero("midjob_reset");
        @(negedge clk);
        rst = 1'b0;
        launch(pk(15, 10, 5, 0), pk(0, 5, 10, 15), 3'd6, 10, 1'b1);
        wait_drain();
        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: sim time exceeded, required finish");
        $fatal(1);
    end

endmodule
